// File: rtl/scan_shift_update_if.sv
// Bus bundle for the scan shift/update register: scan path, capture path,
// update request and the functional/status outputs.
interface scan_shift_update_if #(
    parameter int WIDTH = 10
);
    logic             i_scan_en;
    logic             i_scan_in;
    logic             o_scan_out;
    logic             i_capture;
    logic [WIDTH-1:0] i_d;
    logic             i_update;
    logic [WIDTH-1:0] o_q;
    logic             o_updated;
    logic             o_err;
    logic             i_err_clr;

    // Driver side (scan controller / bench)
    modport master (
        output i_scan_en, i_scan_in, i_capture, i_d, i_update, i_err_clr,
        input  o_scan_out, o_q, o_updated, o_err
    );

    // Register side
    modport slave (
        input  i_scan_en, i_scan_in, i_capture, i_d, i_update, i_err_clr,
        output o_scan_out, o_q, o_updated, o_err
    );
endinterface

// File: rtl/scan_shift_update_reg.sv
// Scan configuration register: serial shift chain with parallel capture and
// a shadow update register feeding the functional outputs. An update only
// commits after exactly WIDTH shifts since the last capture/commit; any
// other update attempt raises a sticky error.
module scan_shift_update_reg #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    scan_shift_update_if.slave   bus
);
    // Counter must reach WIDTH+1 so over-shifts stay distinguishable.
    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             updated_q, updated_d;
    logic             err_q, err_d;
    logic             err_set;

    // Next-state: capture beats shift beats update; at most one happens.
    always_comb begin
        shreg_d   = shreg_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        updated_d = 1'b0;
        err_set   = 1'b0;

        if (bus.i_capture) begin
            shreg_d = bus.i_d;
            cnt_d   = '0;
            err_set = bus.i_update;
        end else if (bus.i_scan_en) begin
            shreg_d = {bus.i_scan_in, shreg_q[WIDTH-1:1]};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CW'(1);
            end
            err_set = bus.i_update;
        end else if (bus.i_update) begin
            if (cnt_q == CNT_FULL) begin
                q_d       = shreg_q;
                updated_d = 1'b1;
                cnt_d     = '0;
            end else begin
                err_set   = 1'b1;
            end
        end

        // An error event in the same cycle as a clear keeps the flag set.
        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.i_err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg_q   <= '0;
            q_q       <= RESET_VAL;
            cnt_q     <= '0;
            updated_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            updated_q <= updated_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_scan_out = shreg_q[0];
    assign bus.o_q        = q_q;
    assign bus.o_updated  = updated_q;
    assign bus.o_err      = err_q;

endmodule

// File: tb/tb_scan_shift_update_reg.sv
// Directed plus randomized bench for scan_shift_update_reg (WIDTH=10).
// Outputs are compared every cycle against a behavioural model of the
// shift/capture/update rules, with extra constant checks at key points.
module tb_scan_shift_update_reg;
    localparam int W = 10;

    logic i_clk;
    logic i_rst_n;
    int   checks = 0;
    int   errors = 0;

    scan_shift_update_if #(.WIDTH(W)) bus ();

    scan_shift_update_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural model state
    logic [W-1:0] m_sh;
    logic [W-1:0] m_q;
    int           m_cnt;
    logic         m_upd;
    logic         m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sh  = '0;
        m_q   = '0;
        m_cnt = 0;
        m_upd = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic cap, input logic en, input logic sin,
                              input logic upd, input logic clr, input logic [W-1:0] d);
        logic set;
        set   = 1'b0;
        m_upd = 1'b0;
        if (cap) begin
            m_sh  = d;
            m_cnt = 0;
            set   = upd;
        end else if (en) begin
            m_sh  = (m_sh >> 1) | (W'(sin) << (W - 1));
            m_cnt = (m_cnt + 1 > W + 1) ? W + 1 : m_cnt + 1;
            set   = upd;
        end else if (upd) begin
            if (m_cnt == W) begin
                m_q   = m_sh;
                m_cnt = 0;
                m_upd = 1'b1;
            end else begin
                set = 1'b1;
            end
        end
        if (set)      m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    // One clock: drive strobes, advance model at the edge, check #1 later.
    task automatic cycle(input logic cap, input logic en, input logic sin,
                         input logic upd, input logic clr, input logic [W-1:0] d);
        bus.i_capture = cap;
        bus.i_scan_en = en;
        bus.i_scan_in = en ? sin : 1'bx;
        bus.i_update  = upd;
        bus.i_err_clr = clr;
        bus.i_d       = d;
        @(posedge i_clk);
        model_step(cap, en, sin, upd, clr, d);
        #1;
        check("scan_out", 32'(bus.o_scan_out), 32'(m_sh[0]));
        check("q",        32'(bus.o_q),        32'(m_q));
        check("updated",  32'(bus.o_updated),  32'(m_upd));
        check("err",      32'(bus.o_err),      32'(m_err));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic shift_word(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, w[i % W], 1'b0, 1'b0, '0);
        end
    endtask

    task automatic update();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic err_clear();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    initial begin
        logic [W-1:0] w;
        int           n;
        logic         cap, en, sin, upd, clr;

        bus.i_capture = 1'b0;
        bus.i_scan_en = 1'b0;
        bus.i_scan_in = 1'b0;
        bus.i_update  = 1'b0;
        bus.i_err_clr = 1'b0;
        bus.i_d       = '0;
        i_rst_n       = 1'b0;
        model_reset();
        #12;
        check("rst_q",        32'(bus.o_q),        32'h0);
        check("rst_scan_out", 32'(bus.o_scan_out), 32'h0);
        check("rst_updated",  32'(bus.o_updated),  32'h0);
        check("rst_err",      32'(bus.o_err),      32'h0);
        i_rst_n = 1'b1;

        // 1: full shift of 0x2B5 then commit
        shift_word(10'h2B5, W);
        check("s1_q_before_update", 32'(bus.o_q), 32'h0);
        update();
        check("s1_q",       32'(bus.o_q),       32'h2B5);
        check("s1_updated", 32'(bus.o_updated), 32'h1);
        check("s1_err",     32'(bus.o_err),     32'h0);
        idle();
        check("s1_updated_pulse", 32'(bus.o_updated), 32'h0);

        // 2: under-shift, then finish the word and commit
        shift_word(10'h1C3, W - 1);
        update();
        check("s2_err",     32'(bus.o_err),     32'h1);
        check("s2_q_held",  32'(bus.o_q),       32'h2B5);
        check("s2_no_upd",  32'(bus.o_updated), 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);   // bit 9 of 0x1C3
        update();
        check("s2_q_commit",   32'(bus.o_q),   32'h1C3);
        check("s2_err_sticky", 32'(bus.o_err), 32'h1);
        err_clear();
        check("s2_err_clr", 32'(bus.o_err), 32'h0);
        update();   // repeated update with no shift
        check("s2_repeat_err", 32'(bus.o_err), 32'h1);
        check("s2_repeat_q",   32'(bus.o_q),   32'h1C3);
        err_clear();

        // 3: over-shift saturates the counter
        shift_word(10'h0F0, 12);
        check("s3_cnt_sat", 32'(dut.cnt_q), 32'd11);
        update();
        check("s3_err",    32'(bus.o_err), 32'h1);
        check("s3_q_held", 32'(bus.o_q),   32'h1C3);
        err_clear();
        // Error event together with clear: set wins
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        check("s3_set_wins", 32'(bus.o_err), 32'h1);
        err_clear();

        // 4: capture 0x155 and drain LSB-first
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h155);
        check("s4_out0", 32'(bus.o_scan_out), 32'h1);
        for (int k = 1; k < W; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            check("s4_out_seq", 32'(bus.o_scan_out), (k % 2 == 0) ? 32'h1 : 32'h0);
        end

        // 5: simultaneous strobes
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF);
        check("s5_cap_cnt", 32'(dut.cnt_q),      32'h0);
        check("s5_cap_err", 32'(bus.o_err),      32'h0);
        check("s5_cap_out", 32'(bus.o_scan_out), 32'h1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("s5_shupd_err", 32'(bus.o_err), 32'h1);
        check("s5_shupd_q",   32'(bus.o_q),   32'h1C3);
        check("s5_shupd_cnt", 32'(dut.cnt_q), 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h001);   // capture+update errors
        check("s5_capupd_err", 32'(bus.o_err), 32'h1);
        err_clear();

        // 6: async reset mid-shift
        shift_word(10'h2B5, W);
        update();
        check("s6_q_pre", 32'(bus.o_q), 32'h2B5);
        shift_word(10'h3A5, 5);
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check("s6_rst_q",        32'(bus.o_q),        32'h0);
        check("s6_rst_scan_out", 32'(bus.o_scan_out), 32'h0);
        check("s6_rst_err",      32'(bus.o_err),      32'h0);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        shift_word(10'h2B5, W);
        update();
        check("s6_recommit", 32'(bus.o_q), 32'h2B5);

        // Random words with shift lengths around WIDTH
        for (int it = 0; it < 40; it++) begin
            w = W'($urandom);
            case ($urandom_range(0, 4))
                0:       n = W - 1;
                1:       n = W + 1;
                2:       n = W + 2;
                default: n = W;
            endcase
            if ($urandom_range(0, 4) == 0) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W'($urandom));
            shift_word(w, n);
            update();
            if ($urandom_range(0, 2) == 0) err_clear();
            else idle();
        end

        // Fully random strobes
        for (int it = 0; it < 300; it++) begin
            cap = ($urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 2) != 0);
            sin = 1'($urandom);
            upd = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 9) == 0);
            cycle(cap, en, sin, upd, clr, W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
